// File: rtl/hdlc_pkg.sv
// Shared constants and encodings for the HDLC line-side blocks.
package hdlc_pkg;

  localparam logic [7:0]  FLAG        = 8'h7E;
  localparam logic [15:0] CRC_INIT    = 16'hFFFF;
  localparam logic [15:0] CRC_POLY    = 16'h1021;
  localparam logic [15:0] CRC_RESIDUE = 16'h1D0F;

  typedef enum logic [1:0] {
    HUNT = 2'd0,
    SYNC = 2'd1,
    DATA = 2'd2
  } state_e;

  typedef enum logic [2:0] {
    ST_OK    = 3'd0,
    ST_CRC   = 3'd1,
    ST_ALIGN = 3'd2,
    ST_SHORT = 3'd3,
    ST_ABORT = 3'd4,
    ST_LONG  = 3'd5
  } status_e;

endpackage

// File: rtl/hdlc_rx_deframer_if.sv
// Payload/status bus from the deframer to the packet buffer.
interface hdlc_rx_deframer_if
  import hdlc_pkg::*;
#(
  parameter int unsigned LEN_W = 16
) ();

  logic [7:0]       o_data_out;
  logic             o_data_valid;
  logic             o_data_first;
  logic             o_frame_end;
  status_e          o_frame_status;
  logic [LEN_W-1:0] o_frame_len;

  modport master (
    output o_data_out, o_data_valid, o_data_first,
    output o_frame_end, o_frame_status, o_frame_len
  );

  modport slave (
    input o_data_out, o_data_valid, o_data_first,
    input o_frame_end, o_frame_status, o_frame_len
  );

endinterface

// File: rtl/hdlc_crc16_byte.sv
// CRC-16 (poly 1021) advanced over one byte, bit0 first, serial steps unrolled.
module hdlc_crc16_byte
  import hdlc_pkg::*;
(
  input  logic [15:0] i_crc_in,
  input  logic [7:0]  i_byte,
  output logic [15:0] o_crc_out_c
);

  always_comb begin
    o_crc_out_c = i_crc_in;
    for (int i = 0; i < 8; i++) begin
      if (i_byte[i] ^ o_crc_out_c[15]) o_crc_out_c = {o_crc_out_c[14:0], 1'b0} ^ CRC_POLY;
      else                             o_crc_out_c = {o_crc_out_c[14:0], 1'b0};
    end
  end

endmodule

// File: rtl/hdlc_rx_deframer.sv
// HDLC receive deframer: flag hunt, destuffing, abort detection, byte
// assembly with FCS withholding and CRC check, per-frame status strobe.
module hdlc_rx_deframer
  import hdlc_pkg::*;
#(
  parameter int unsigned MAX_LEN = 1024,
  parameter int unsigned LEN_W   = 16
) (
  input  logic                  i_netclk,
  input  logic                  i_reset,
  input  logic                  i_rxdata,
  hdlc_rx_deframer_if.master    m_out
);

  localparam logic [LEN_W-1:0] LONG_CNT = LEN_W'(MAX_LEN + 3);

  state_e           r_state, w_state_nx;
  logic [2:0]       r_ones;
  logic [2:0]       r_bitn;
  logic [LEN_W-1:0] r_byte_cnt;
  logic [15:0]      r_crc;
  logic [6:0]       r_sr;
  logic [7:0]       r_d0, r_d1;

  logic [7:0]       r_data_out;
  logic             r_data_valid, r_data_first, r_frame_end;
  status_e          r_frame_status;
  logic [LEN_W-1:0] r_frame_len;

  logic             w_flag, w_abort, w_stuff, w_data_bit;
  logic [7:0]       w_byte;
  logic [15:0]      w_crc_nx;
  logic [LEN_W-1:0] w_cnt_inc, w_len;
  logic             w_shift, w_complete, w_emit, w_end, w_reinit;
  status_e          w_status;

  // Line-bit classification from the run of preceding ones
  assign w_flag     = !i_rxdata && (r_ones == 3'd6);
  assign w_abort    =  i_rxdata && (r_ones == 3'd6);
  assign w_stuff    = !i_rxdata && (r_ones == 3'd5);
  assign w_data_bit =  i_rxdata ? (r_ones < 3'd6) : (r_ones != 3'd6);

  assign w_byte    = {i_rxdata, r_sr};
  assign w_cnt_inc = r_byte_cnt + LEN_W'(1);
  assign w_len     = (r_byte_cnt >= LEN_W'(2)) ? (r_byte_cnt - LEN_W'(2)) : '0;

  hdlc_crc16_byte u_crc (
    .i_crc_in    (r_crc),
    .i_byte      (w_byte),
    .o_crc_out_c (w_crc_nx)
  );

  always_ff @(posedge i_netclk or posedge i_reset) begin
    if (i_reset) r_state <= HUNT;
    else         r_state <= w_state_nx;
  end

  always_comb begin
    w_state_nx = r_state;
    w_shift    = 1'b0;
    w_complete = 1'b0;
    w_emit     = 1'b0;
    w_end      = 1'b0;
    w_reinit   = 1'b0;
    w_status   = ST_OK;
    case (r_state)
      HUNT: begin
        if (w_flag) begin
          w_state_nx = SYNC;
          w_reinit   = 1'b1;
        end
      end
      SYNC: begin
        if (w_data_bit) begin
          w_state_nx = DATA;
          w_shift    = 1'b1;
        end else if (w_abort) begin
          w_state_nx = HUNT;
          w_reinit   = 1'b1;
        end
      end
      DATA: begin
        if (w_data_bit && !w_stuff) begin
          w_shift = 1'b1;
          if (r_bitn == 3'd7) begin
            w_complete = 1'b1;
            if (w_cnt_inc == LONG_CNT) begin
              w_end      = 1'b1;
              w_status   = ST_LONG;
              w_state_nx = HUNT;
              w_reinit   = 1'b1;
            end else if (r_byte_cnt >= LEN_W'(2)) begin
              w_emit = 1'b1;
            end
          end
        end else if (w_flag) begin
          w_state_nx = SYNC;
          w_reinit   = 1'b1;
          w_end      = 1'b1;
          if (r_bitn != 3'd7)                w_status = ST_ALIGN;
          else if (r_byte_cnt == '0)         w_end    = 1'b0;
          else if (r_byte_cnt <= LEN_W'(2))  w_status = ST_SHORT;
          else if (r_crc != CRC_RESIDUE)     w_status = ST_CRC;
          else                               w_status = ST_OK;
        end else if (w_abort) begin
          w_state_nx = HUNT;
          w_reinit   = 1'b1;
          if ((r_byte_cnt != '0) || (r_bitn != 3'd0)) begin
            w_end    = 1'b1;
            w_status = ST_ABORT;
          end
        end
      end
      default: begin
        w_state_nx = HUNT;
        w_reinit   = 1'b1;
      end
    endcase
  end

  // Datapath: ones run, byte assembly, CRC, two-byte FCS delay line, outputs
  always_ff @(posedge i_netclk or posedge i_reset) begin
    if (i_reset) begin
      r_ones         <= 3'd0;
      r_bitn         <= 3'd0;
      r_byte_cnt     <= '0;
      r_crc          <= CRC_INIT;
      r_sr           <= 7'd0;
      r_d0           <= 8'd0;
      r_d1           <= 8'd0;
      r_data_out     <= 8'd0;
      r_data_valid   <= 1'b0;
      r_data_first   <= 1'b0;
      r_frame_end    <= 1'b0;
      r_frame_status <= ST_OK;
      r_frame_len    <= '0;
    end else begin
      r_ones       <= i_rxdata ? ((r_ones == 3'd7) ? 3'd7 : r_ones + 3'd1) : 3'd0;
      r_data_valid <= w_emit;
      r_data_first <= w_emit && (r_byte_cnt == LEN_W'(2));
      r_frame_end  <= w_end;
      if (w_emit) r_data_out <= r_d1;
      if (w_end) begin
        r_frame_status <= w_status;
        r_frame_len    <= w_len;
      end
      if (w_reinit) begin
        r_bitn     <= 3'd0;
        r_byte_cnt <= '0;
        r_crc      <= CRC_INIT;
        r_d0       <= 8'd0;
        r_d1       <= 8'd0;
      end else if (w_shift) begin
        r_sr   <= w_byte[7:1];
        r_bitn <= r_bitn + 3'd1;
        if (w_complete) begin
          r_byte_cnt <= w_cnt_inc;
          r_crc      <= w_crc_nx;
          r_d0       <= w_byte;
          r_d1       <= r_d0;
        end
      end
    end
  end

  assign m_out.o_data_out     = r_data_out;
  assign m_out.o_data_valid   = r_data_valid;
  assign m_out.o_data_first   = r_data_first;
  assign m_out.o_frame_end    = r_frame_end;
  assign m_out.o_frame_status = r_frame_status;
  assign m_out.o_frame_len    = r_frame_len;

endmodule

// File: tb/tb_hdlc_rx_deframer.sv
// Directed bench for hdlc_rx_deframer: bit-level encoder drives the line,
// a negedge monitor collects byte/end events, scoreboards compare per test.
module tb_hdlc_rx_deframer;
  import hdlc_pkg::*;

  localparam int unsigned LEN_W = 16;

  logic clk, reset, rxdata;
  hdlc_rx_deframer_if #(.LEN_W(LEN_W)) bus ();

  hdlc_rx_deframer #(.MAX_LEN(4), .LEN_W(LEN_W)) dut (
    .i_netclk (clk),
    .i_reset  (reset),
    .i_rxdata (rxdata),
    .m_out    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  int n_overlap = 0;
  int enc_ones = 0;
  logic [15:0] last_fcs;
  logic [7:0]  tx_q[$];
  logic [8:0]  obs_data[$], exp_data[$];
  logic [18:0] obs_end[$],  exp_end[$];

  always @(negedge clk) begin
    if (bus.o_data_valid) obs_data.push_back({bus.o_data_first, bus.o_data_out});
    if (bus.o_frame_end)  obs_end.push_back({3'(bus.o_frame_status), bus.o_frame_len});
    if (bus.o_data_valid && bus.o_frame_end) n_overlap++;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic compare_events(input string tag);
    check_eq({tag, "/n_bytes"}, 32'(obs_data.size()), 32'(exp_data.size()));
    for (int i = 0; i < exp_data.size(); i++)
      if (i < obs_data.size())
        check_eq($sformatf("%s/byte%0d", tag, i), 32'(obs_data[i]), 32'(exp_data[i]));
    check_eq({tag, "/n_ends"}, 32'(obs_end.size()), 32'(exp_end.size()));
    for (int i = 0; i < exp_end.size(); i++)
      if (i < obs_end.size())
        check_eq($sformatf("%s/end%0d", tag, i), 32'(obs_end[i]), 32'(exp_end[i]));
    obs_data.delete(); exp_data.delete();
    obs_end.delete();  exp_end.delete();
  endtask

  function automatic logic [15:0] crc_bit(input logic [15:0] c, input logic b);
    return (b ^ c[15]) ? ({c[14:0], 1'b0} ^ 16'h1021) : {c[14:0], 1'b0};
  endfunction

  function automatic logic [7:0] rev8(input logic [7:0] v);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[i] = v[7-i];
    return r;
  endfunction

  task automatic push_byte(input logic first, input logic [7:0] v);
    exp_data.push_back({first, v});
  endtask

  task automatic push_end(input status_e st, input int len);
    exp_end.push_back({3'(st), LEN_W'(len)});
  endtask

  task automatic send_bit(input logic b);
    @(negedge clk);
    rxdata = b;
  endtask

  task automatic send_flag();
    logic [7:0] f;
    f = FLAG;
    for (int j = 0; j < 8; j++) send_bit(f[j]);
    enc_ones = 0;
  endtask

  task automatic send_data_bit(input logic b);
    send_bit(b);
    if (b) begin
      enc_ones++;
      if (enc_ones == 5) begin
        send_bit(1'b0);
        enc_ones = 0;
      end
    end else begin
      enc_ones = 0;
    end
  endtask

  // Payload LSB-first; optional single bit flip after CRC, inverted FCS MSB-first, extra 0
  task automatic send_body(input int flip_idx, input int flip_bit, input bit with_fcs, input bit extra_zero);
    logic [15:0] c;
    logic b;
    c = 16'hFFFF;
    foreach (tx_q[i]) begin
      for (int j = 0; j < 8; j++) begin
        b = tx_q[i][j];
        c = crc_bit(c, b);
        if (i == flip_idx && j == flip_bit) b = ~b;
        send_data_bit(b);
      end
    end
    last_fcs = ~c;
    if (with_fcs) for (int k = 15; k >= 0; k--) send_data_bit(last_fcs[k]);
    if (extra_zero) send_data_bit(1'b0);
  endtask

  initial begin
    reset  = 1'b1;
    rxdata = 1'b1;
    repeat (3) @(negedge clk);
    check_eq("rst/data_out",     32'(bus.o_data_out),     32'h0);
    check_eq("rst/data_valid",   32'(bus.o_data_valid),   32'h0);
    check_eq("rst/data_first",   32'(bus.o_data_first),   32'h0);
    check_eq("rst/frame_end",    32'(bus.o_frame_end),    32'h0);
    check_eq("rst/frame_status", 32'(bus.o_frame_status), 32'h0);
    check_eq("rst/frame_len",    32'(bus.o_frame_len),    32'h0);
    reset = 1'b0;

    repeat (16) send_bit(1'b1);
    compare_events("idle_hunt");

    send_flag(); tx_q = '{8'h01, 8'h02, 8'h03};
    send_body(-1, 0, 1'b1, 1'b0); send_flag(); send_flag();
    push_byte(1'b1, 8'h01); push_byte(1'b0, 8'h02); push_byte(1'b0, 8'h03);
    push_end(ST_OK, 3);
    compare_events("ok");

    send_flag(); tx_q = '{8'hFF, 8'h7E, 8'hFC, 8'h3F};
    send_body(-1, 0, 1'b1, 1'b0); send_flag(); send_flag();
    push_byte(1'b1, 8'hFF); push_byte(1'b0, 8'h7E); push_byte(1'b0, 8'hFC); push_byte(1'b0, 8'h3F);
    push_end(ST_OK, 4);
    compare_events("stuff");

    send_flag(); tx_q = '{8'h01, 8'h02, 8'h03};
    send_body(1, 3, 1'b1, 1'b0); send_flag(); send_flag();
    push_byte(1'b1, 8'h01); push_byte(1'b0, 8'h0A); push_byte(1'b0, 8'h03);
    push_end(ST_CRC, 3);
    compare_events("crc_err");

    // Three bytes, then seven ones abort (one byte already strobed)
    send_flag(); tx_q = '{8'h01, 8'h02, 8'h03};
    send_body(-1, 0, 1'b0, 1'b0);
    repeat (8)  send_bit(1'b1);
    repeat (16) send_bit(1'b1);
    push_byte(1'b1, 8'h01);
    push_end(ST_ABORT, 1);
    compare_events("abort");

    repeat (24) send_bit(1'b1);
    compare_events("idle_after_abort");

    repeat (10) send_flag();
    compare_events("flags");

    send_flag(); tx_q = '{8'hAA, 8'hBB};
    send_body(-1, 0, 1'b0, 1'b0); send_flag(); send_flag();
    push_end(ST_SHORT, 0);
    compare_events("short");

    // Extra 0 lets the flag's seven bits complete one more byte (first FCS byte)
    send_flag(); tx_q = '{8'h01, 8'h02, 8'h03};
    send_body(-1, 0, 1'b1, 1'b1); send_flag(); send_flag();
    push_byte(1'b1, 8'h01); push_byte(1'b0, 8'h02); push_byte(1'b0, 8'h03);
    push_byte(1'b0, rev8(last_fcs[15:8]));
    push_end(ST_ALIGN, 4);
    compare_events("align");

    send_flag(); tx_q = '{8'h01, 8'h02, 8'h03};
    send_body(-1, 0, 1'b0, 1'b0);
    @(negedge clk); #2;
    check_eq("rst_mid/dv_before", 32'(bus.o_data_valid), 32'h1);
    reset  = 1'b1;
    rxdata = 1'b1;
    #1;
    check_eq("rst_mid/data_valid", 32'(bus.o_data_valid), 32'h0);
    check_eq("rst_mid/data_first", 32'(bus.o_data_first), 32'h0);
    check_eq("rst_mid/data_out",   32'(bus.o_data_out),   32'h0);
    check_eq("rst_mid/frame_end",  32'(bus.o_frame_end),  32'h0);
    repeat (3) @(negedge clk);
    reset    = 1'b0;
    enc_ones = 0;
    send_flag(); tx_q = '{8'h01, 8'h02, 8'h03};
    send_body(-1, 0, 1'b1, 1'b0); send_flag(); send_flag();
    push_byte(1'b1, 8'h01);
    push_byte(1'b1, 8'h01); push_byte(1'b0, 8'h02); push_byte(1'b0, 8'h03);
    push_end(ST_OK, 3);
    compare_events("rst_mid");

    send_flag(); tx_q = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
    send_body(-1, 0, 1'b1, 1'b0); send_flag(); send_flag();
    push_byte(1'b1, 8'h11); push_byte(1'b0, 8'h22); push_byte(1'b0, 8'h33); push_byte(1'b0, 8'h44);
    push_end(ST_LONG, 4);
    compare_events("long");

    check_eq("no_valid_end_overlap", 32'(n_overlap), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
